imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, number of DATA_W-bit words; power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width; one of 32 or 64.
REQ-003 SHALL have parameter LATENCY, default 1, cycles from request accept to response valid; range 1..4.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports req_valid (input, 1), req_ready (output, 1) and req_addr (input, 32): the fetch request channel, with a byte address.
REQ-007 SHALL have ports resp_valid (output, 1), resp_ready (input, 1), resp_data (output, DATA_W) and resp_err (output, 1): the response channel.
REQ-008 SHALL have ports wr_en (input, 1), wr_addr (input, 32) and wr_data (input, DATA_W): the program-load write port, with a byte address.
REQ-009 SHALL have port flush, input, 1, which discards all in-flight and buffered responses.

Function
REQ-010 SHALL form the word index as req_addr[log2(DATA_W/8) +: log2(MEM_DEPTH)]; wr_addr SHALL be decoded the same way.
REQ-011 SHALL accept a request only on a cycle where req_valid=1, req_ready=1 and flush=0.
REQ-012 SHALL make the response to a request accepted in cycle N visible at the output no earlier than cycle N+LATENCY.
REQ-013 SHALL deliver responses strictly in request order.
REQ-014 SHALL transfer a response only on a cycle where resp_valid=1 and resp_ready=1; resp_data and resp_err SHALL hold stable while resp_valid=1 and resp_ready=0.
REQ-015 SHALL buffer responses in a FIFO of depth LATENCY+1.
REQ-016 SHALL track outstanding requests (in flight plus buffered) with a counter.
REQ-017 SHALL drive req_ready=1 only when outstanding < LATENCY+1, so that no response is ever dropped.
REQ-018 SHALL update the outstanding count by +1 on accept, -1 on response transfer, and 0 when both occur in the same cycle.
REQ-019 SHALL, when the request address is out of range (word index >= MEM_DEPTH, counting the upper address bits), return resp_err=1 and resp_data=0.
REQ-020 SHALL, on wr_en=1, write wr_data to the indexed word at the clock edge; an out-of-range wr_addr SHALL be ignored.
REQ-021 SHALL return the new data when a read is accepted in the same cycle as a write to the same word (write-first).
REQ-022 SHALL, on flush=1, invalidate all pipeline stages and clear the FIFO and the counter at that edge.
REQ-023 SHALL drive resp_valid=0 in the cycle after flush, and SHALL keep req_ready=0 during the flush cycle.
REQ-024 SHALL let writes proceed during flush.
REQ-025 SHALL keep resp_valid=0 when the FIFO is empty.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, clear pipeline valids, FIFO pointers and the outstanding count.
REQ-027 SHALL drive outputs to req_ready=1, resp_valid=0, resp_data=0 and resp_err=0 in the cycle after reset.
REQ-028 SHALL leave memory contents unchanged by reset.
REQ-029 SHALL discard any request or response in progress when reset occurs mid-operation, and SHALL not deliver it afterwards.
REQ-030 SHALL give rst priority over flush and wr_en; no write occurs during reset.

Configuration
REQ-031 SHALL, with macro IMEM_MISALIGN_CHK_EN defined, flag a request whose req_addr[log2(DATA_W/8)-1:0] != 0 with resp_err=1 and resp_data=0, and SHALL silently drop such writes.
REQ-032 SHALL, without IMEM_MISALIGN_CHK_EN, ignore the low address bits for both reads and writes, with no error raised.

Verification
REQ-033 Reset then write: rst for 2 cycles, write 0xDEADBEEF at 0x10, then with LATENCY=2 read 0x10 -> resp_valid in cycle N+2 with 0xDEADBEEF, resp_err=0.
REQ-034 Backpressure: LATENCY=3, resp_ready=0, issue 6 back-to-back reads -> exactly 4 accepted, req_ready=0 after the 4th; release resp_ready -> 4 responses in order, no loss.
REQ-035 Out of range: MEM_DEPTH=1024, read 0x1000 -> resp_err=1, resp_data=0.
REQ-036 Write-first: write 0x12345678 to 0x20 and read 0x20 in the same cycle -> response 0x12345678.
REQ-037 Flush: flush with 3 outstanding -> resp_valid=0 next cycle, req_ready=1, and later reads return correctly.
REQ-038 Misaligned: read 0x22 with IMEM_MISALIGN_CHK_EN -> resp_err=1; without it -> data of word 0x20, resp_err=0.

Source files
------------

// File: rtl/imem_fetch_if.sv
// imem_fetch_if: fetch request channel and in-order response channel between a
// front end (master) and the instruction memory (slave).
interface imem_fetch_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/imem_fetch.sv
// imem_fetch: instruction memory with a LATENCY-deep read pipeline feeding an
// in-order response FIFO. Define IMEM_MISALIGN_CHK_EN to reject misaligned accesses.
module imem_fetch #(
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LATENCY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_if.slave       bus,
  input  logic              wr_en,
  input  logic [31:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush
);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned HI    = IDX_W + OFF_W;
  localparam int unsigned DEPTH = LATENCY + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef logic [DATA_W:0] entry_t; // {err, data}

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  entry_t            fifo_q [DEPTH];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rd_err, wr_ok, acc, pop, push;
  entry_t           rd_ent, push_ent;
  logic [CNT_W-1:0] cnt_q, cnt_d, fcnt_q, fcnt_d;
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Address decode; an access is out of range when any bit above the index is set.
  always_comb begin
    rd_idx = bus.req_addr[OFF_W +: IDX_W];
    wr_idx = wr_addr[OFF_W +: IDX_W];
    rd_err = (bus.req_addr >> HI) != '0;
    wr_ok  = wr_en && ((wr_addr >> HI) == '0);
`ifdef IMEM_MISALIGN_CHK_EN
    rd_err = rd_err || (bus.req_addr[OFF_W-1:0] != '0);
    wr_ok  = wr_ok && (wr_addr[OFF_W-1:0] == '0);
`endif
    if (rd_err)
      rd_ent = {1'b1, {DATA_W{1'b0}}};
    else if (wr_ok && (wr_idx == rd_idx))
      rd_ent = {1'b0, wr_data};
    else
      rd_ent = {1'b0, mem[rd_idx]};
  end

  always_comb begin
    bus.req_ready  = !rst && !flush && (cnt_q < CNT_W'(DEPTH));
    acc            = bus.req_valid && bus.req_ready;
    bus.resp_valid = (fcnt_q != '0);
    pop            = bus.resp_valid && bus.resp_ready;
    {bus.resp_err, bus.resp_data} = bus.resp_valid ? fifo_q[rp_q] : '0;
    cnt_d  = cnt_q + CNT_W'(acc) - CNT_W'(pop);
    fcnt_d = fcnt_q + CNT_W'(push) - CNT_W'(pop);
    wp_d   = push ? nxt(wp_q) : wp_q;
    rp_d   = pop  ? nxt(rp_q) : rp_q;
  end

  // The FIFO write is the last latency stage, so only LATENCY-1 pipeline registers exist.
  if (LATENCY == 1) begin : g_nopipe
    always_comb begin
      push     = acc;
      push_ent = rd_ent;
    end
  end else begin : g_pipe
    localparam int unsigned PS = LATENCY - 1;
    logic [PS-1:0]              v_q;
    logic [PS-1:0][DATA_W:0]    e_q;

    always_ff @(posedge clk) begin
      if (rst || flush) v_q <= '0;
      else              v_q <= PS'({v_q, acc});
    end

    always_ff @(posedge clk) begin
      e_q <= (PS * (DATA_W + 1))'({e_q, rd_ent});
    end

    always_comb begin
      push     = v_q[PS-1];
      push_ent = e_q[PS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_idx] <= wr_data;
  end
endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed vector table plus hand-written backpressure, flush and
// reset sequences for imem_fetch (LATENCY=3, MEM_DEPTH=1024, DATA_W=32).
module tb_imem_fetch;
  localparam int LAT = 3;
`ifdef IMEM_MISALIGN_CHK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        flush;
  int          nvec = 0;
  int          nerr = 0;

  imem_fetch_if #(.DATA_W(32)) bus ();

  imem_fetch #(.MEM_DEPTH(1024), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .flush   (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } vec_t;

  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [31:0] a,
                          input logic [31:0] exp_d, input bit exp_e);
    int n;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    #1;
    chk({nm, "_rdy"}, bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.resp_valid && n < 12) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, n, LAT);
    chk({nm, "_data"}, bus.resp_data, exp_d);
    chk({nm, "_err"}, bus.resp_err, exp_e);
    step();
  endtask

  initial begin
    int   acc_n;
    int   seen;
    logic [31:0] w;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[8]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 1'b1};
    tbl[9]  = '{1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 1'b0};
    tbl[10] = '{1'b0, 32'h0000_0024, 32'hA5A5_A5A5, 1'b0};
    tbl[11] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_0022, 32'h2222_2222, 1'b0};
    tbl[13] = '{1'b0, 32'h0000_0022, MIS ? 32'h0 : 32'h2222_2222, MIS};

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_err", bus.resp_err, 0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else rd_check($sformatf("vec%0d", i), tbl[i].addr, tbl[i].data, tbl[i].err);
    end
    rd_check("mis_word20", 32'h20, MIS ? 32'h1111_1111 : 32'h2222_2222, 1'b0);

    // Write-first: read and write of the same word in one cycle.
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'h1234_5678;
    bus.req_valid = 1'b1; bus.req_addr = 32'h20;
    step();
    wr_en = 1'b0; bus.req_valid = 1'b0;
    seen = 1;
    while (!bus.resp_valid && seen < 12) begin step(); seen++; end
    chk("wf_lat", seen, LAT);
    chk("wf_data", bus.resp_data, 32'h1234_5678);
    step();

    // Backpressure: hold requests until accepted with resp_ready low.
    for (int i = 0; i < LAT + 3; i++) wr(32'h100 + 4 * i, 32'hB000_0000 + i);
    bus.resp_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h100 + 4 * acc_n;
      #1;
      if (bus.req_ready) acc_n++;
      step();
    end
    chk("bp_accepted", acc_n, LAT + 1);
    chk("bp_ready_low", bus.req_ready, 0);
    bus.req_valid = 1'b0;
    step();
    chk("bp_hold0", bus.resp_data, 32'hB000_0000);
    step();
    chk("bp_hold1", bus.resp_data, 32'hB000_0000);
    bus.resp_ready = 1'b1;
    #1;
    for (int j = 0; j < LAT + 1; j++) begin
      chk($sformatf("bp_valid%0d", j), bus.resp_valid, 1);
      chk($sformatf("bp_data%0d", j), bus.resp_data, 32'hB000_0000 + j);
      step();
    end
    chk("bp_drained", bus.resp_valid, 0);
    chk("bp_ready_back", bus.req_ready, 1);

    // Flush with three outstanding; a write issued alongside flush must land.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = 32'h100 + 4 * i;
      step();
    end
    flush = 1'b1; wr_en = 1'b1; wr_addr = 32'h28; wr_data = 32'h5A5A_0028;
    #1;
    chk("fl_ready_during", bus.req_ready, 0);
    step();
    flush = 1'b0; wr_en = 1'b0; bus.req_valid = 1'b0;
    #1;
    chk("fl_valid_after", bus.resp_valid, 0);
    chk("fl_ready_after", bus.req_ready, 1);
    seen = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      if (bus.resp_valid) seen++;
    end
    chk("fl_no_stale", seen, 0);
    rd_check("fl_wr28", 32'h28, 32'h5A5A_0028, 1'b0);
    rd_check("fl_rd24", 32'h24, 32'hA5A5_A5A5, 1'b0);

    // Reset mid-operation: in-flight reads vanish, write under reset is ignored.
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = 32'h100 + 4 * i;
      step();
    end
    rst = 1'b1; wr_en = 1'b1; wr_addr = 32'h24; wr_data = 32'hFFFF_FFFF;
    step();
    rst = 1'b0; wr_en = 1'b0; bus.req_valid = 1'b0;
    #1;
    chk("mr_ready", bus.req_ready, 1);
    chk("mr_valid", bus.resp_valid, 0);
    seen = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      if (bus.resp_valid) seen++;
    end
    chk("mr_no_stale", seen, 0);
    rd_check("mr_rd24", 32'h24, 32'hA5A5_A5A5, 1'b0);
    rd_check("mr_rd10", 32'h10, 32'hDEAD_BEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
